// File: rtl/calc_key_entry.sv
// Calculator key entry: switch sampling/debounce, key events, BCD operand entry FSM, LCD line-1 ASCII buffer.
// Build option: define KEY_REPEAT_EN to auto-repeat held digit keys every 50 sample ticks.
module calc_key_entry #(
    parameter int TICK_DIV       = 5,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int MAX_DIGITS     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             sw,
    input  logic [7:0]              dipsw,
    input  logic [3:0]              rd_addr,
    output logic [7:0]              rd_data,
    output logic                    key_evt,
    output logic [4:0]              key_code,
    output logic [4*MAX_DIGITS-1:0] operand_a,
    output logic [4*MAX_DIGITS-1:0] operand_b,
    output logic [2:0]              op_code,
    output logic                    calc_go,
    output logic [7:0]              led,
    output logic [1:0]              entry_state
);

    // state  | meaning
    // S_A    | entering operand A
    // S_B    | binary operator latched, entering operand B
    // S_DONE | expression complete, calc_go issued
    localparam logic [1:0] S_A    = 2'd0;
    localparam logic [1:0] S_B    = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int OW    = 4 * MAX_DIGITS;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DB_W-1:0]  DB_N     = DB_W'(DEBOUNCE_TICKS);
    localparam logic [2:0]       MAX_LEN  = 3'(MAX_DIGITS);
    localparam logic [4:0]       K_CLR    = 5'd10;
    localparam logic [4:0]       K_CE     = 5'd11;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    logic [19:0] sample;
    logic        cand_valid;
    logic [4:0]  cand_code;

    assign sample     = {sw, dipsw};
    assign cand_valid = (sample != '0) && ((sample & (sample - 20'd1)) == '0);

    // sample[19:10] = digits 0..9, [9] CLR, [8] CE, [7:0] operators coded 16..23
    always_comb begin
        cand_code = '0;
        for (int i = 0; i < 20; i++) begin
            if (sample[i]) cand_code = (i >= 8) ? 5'(19 - i) : 5'(23 - i);
        end
    end

    logic            prev_valid;
    logic [4:0]      prev_code;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_next;
    logic            locked;
    logic            same;
    logic            reached;
    logic            accept;
    logic            repeat_hit;

    always_comb begin
        same = (cand_valid == prev_valid) && (!cand_valid || (cand_code == prev_code));
        if (!same)               db_next = DB_W'(1);
        else if (db_cnt == DB_N) db_next = DB_N;
        else                     db_next = db_cnt + 1'b1;
        reached = tick && (db_next == DB_N) && !(same && (db_cnt == DB_N));
        accept  = reached && cand_valid && !locked;
    end

`ifdef KEY_REPEAT_EN
    localparam logic [5:0] RPT_LAST = 6'd49;
    logic [5:0] rpt_cnt;

    assign repeat_hit = tick && locked && same && cand_valid && (cand_code <= 5'd9)
                        && (cand_code == key_code) && (rpt_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                         rpt_cnt <= RPT_LAST;
        else if (accept || repeat_hit)   rpt_cnt <= RPT_LAST;
        else if (tick && rpt_cnt != '0)  rpt_cnt <= rpt_cnt - 1'b1;
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid <= 1'b0;
            prev_code  <= '0;
            db_cnt     <= '0;
            locked     <= 1'b0;
            key_evt    <= 1'b0;
            key_code   <= '0;
        end else begin
            key_evt <= accept || repeat_hit;
            if (tick) begin
                prev_valid <= cand_valid;
                prev_code  <= cand_code;
                db_cnt     <= db_next;
                if (reached) locked <= cand_valid;
            end
            if (accept) key_code <= cand_code;
        end
    end

    function automatic logic [7:0] op_char(input logic [2:0] op);
        case (op)
            3'd0:    op_char = 8'h2B;
            3'd1:    op_char = 8'h2D;
            3'd2:    op_char = 8'hD7;
            3'd3:    op_char = 8'h2F;
            3'd4:    op_char = 8'hF7;
            3'd5:    op_char = 8'h5E;
            3'd6:    op_char = 8'h21;
            default: op_char = 8'h3D;
        endcase
    endfunction

    logic [1:0]    state;
    logic [2:0]    len_a;
    logic [2:0]    len_b;
    logic [7:0]    line_buf [16];
    logic [3:0]    pos_op;
    logic [3:0]    pos_b;
    logic [OW-1:0] digit_w;
    logic [7:0]    digit_ch;
    logic [2:0]    key_op;
    logic          is_digit;

    // operator char sits right after A; B digits follow it
    assign pos_op   = 4'(len_a);
    assign pos_b    = pos_op + 4'd1 + 4'(len_b);
    assign digit_w  = OW'(key_code[3:0]);
    assign digit_ch = {4'h3, key_code[3:0]};
    assign key_op   = key_code[2:0];
    assign is_digit = !key_code[4] && (key_code <= 5'd9);

    assign entry_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_A;
            operand_a <= '0;
            operand_b <= '0;
            op_code   <= '0;
            led       <= '0;
            calc_go   <= 1'b0;
            len_a     <= '0;
            len_b     <= '0;
            for (int i = 0; i < 16; i++) line_buf[i] <= 8'h20;
        end else begin
            calc_go <= 1'b0;
            if (key_evt) begin
                if (key_code == K_CLR) begin
                    state     <= S_A;
                    operand_a <= '0;
                    operand_b <= '0;
                    op_code   <= '0;
                    led       <= '0;
                    len_a     <= '0;
                    len_b     <= '0;
                    for (int i = 0; i < 16; i++) line_buf[i] <= 8'h20;
                end else if (key_code == K_CE) begin
                    case (state)
                        S_A: begin
                            if (len_a != '0) begin
                                operand_a              <= operand_a >> 4;
                                len_a                  <= len_a - 1'b1;
                                line_buf[pos_op - 4'd1] <= 8'h20;
                            end
                        end
                        S_B: begin
                            if (len_b != '0) begin
                                operand_b              <= operand_b >> 4;
                                len_b                  <= len_b - 1'b1;
                                line_buf[pos_b - 4'd1] <= 8'h20;
                            end else begin
                                op_code          <= '0;
                                led              <= '0;
                                line_buf[pos_op] <= 8'h20;
                                state            <= S_A;
                            end
                        end
                        default: ;
                    endcase
                end else if (is_digit) begin
                    case (state)
                        S_A: begin
                            if (len_a < MAX_LEN) begin
                                operand_a        <= (operand_a << 4) | digit_w;
                                len_a            <= len_a + 1'b1;
                                line_buf[pos_op] <= digit_ch;
                            end
                        end
                        S_B: begin
                            if (len_b < MAX_LEN) begin
                                operand_b       <= (operand_b << 4) | digit_w;
                                len_b           <= len_b + 1'b1;
                                line_buf[pos_b] <= digit_ch;
                            end
                        end
                        default: begin
                            // a digit after a finished expression starts a fresh one
                            operand_a <= digit_w;
                            operand_b <= '0;
                            op_code   <= '0;
                            led       <= '0;
                            len_a     <= 3'd1;
                            len_b     <= '0;
                            state     <= S_A;
                            for (int i = 1; i < 16; i++) line_buf[i] <= 8'h20;
                            line_buf[0] <= digit_ch;
                        end
                    endcase
                end else if (key_code[4]) begin
                    case (state)
                        S_A: begin
                            if (len_a != '0 && key_op != 3'd7) begin
                                op_code          <= key_op;
                                led              <= 8'h80 >> key_op;
                                line_buf[pos_op] <= op_char(key_op);
                                if (key_op == 3'd6) begin
                                    line_buf[pos_op + 4'd1] <= 8'h3D;
                                    calc_go                 <= 1'b1;
                                    state                   <= S_DONE;
                                end else begin
                                    state <= S_B;
                                end
                            end
                        end
                        S_B: begin
                            if (key_op <= 3'd5 && len_b == '0) begin
                                op_code          <= key_op;
                                led              <= 8'h80 >> key_op;
                                line_buf[pos_op] <= op_char(key_op);
                            end else if (key_op == 3'd7 && len_b != '0) begin
                                line_buf[pos_b] <= 8'h3D;
                                calc_go         <= 1'b1;
                                state           <= S_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data <= '0;
        else     rd_data <= line_buf[rd_addr];
    end

endmodule

// File: doc/calc_key_entry.md
Name: calc_key_entry

Overview:
Input stage directly upstream of the LCD/7-segment calculator display controller. It samples and debounces the 12 push switches and 8 DIP switches, and turns each stable press into a single key event. An entry state machine uses those events to assemble operand A, the operator and operand B as BCD, and to maintain a 16-byte ASCII line buffer that the display controller reads to drive LCD line 1.

Parameters:
TICK_DIV, 5, clk cycles per sample tick (tick = 1-cycle pulse when divider reaches TICK_DIV-1)
DEBOUNCE_TICKS, 4, consecutive identical samples required to accept a press or a release
MAX_DIGITS, 3, maximum BCD digits per operand (1..6)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sw  in  12  push switches; sw[11]..sw[2] = digits 0..9, sw[1] = CLR, sw[0] = CE (delete last digit)
dipsw  in  8  operator switches; [7..0] = + - x / % ^ ! =
rd_addr  in  4  line-buffer read address (0..15)
rd_data  out  8  ASCII byte at rd_addr, registered, 1-cycle latency
key_evt  out  1  one-cycle pulse per accepted key
key_code  out  5  code of the last accepted key (0-9 digits, 10 CLR, 11 CE, 16-23 dipsw[7..0])
operand_a  out  4*MAX_DIGITS  BCD operand A, least-significant digit in [3:0]
operand_b  out  4*MAX_DIGITS  BCD operand B
op_code  out  3  latched operator (0 = +, 7 = =, per dipsw bit order)
calc_go  out  1  one-cycle pulse when an expression is complete
led  out  8  one-hot copy of the latched operator; 0 when none is latched
entry_state  out  2  0 = S_A, 1 = S_B, 2 = S_DONE

Behaviour:
- Reset (asynchronous, clears everything including the divider and debounce counters):
  - All outputs 0 except entry_state = S_A.
  - All 16 buffer bytes = 0x20; digit counts len_a = len_b = 0.
- Sampling and debounce (on tick only):
  - sample = {sw, dipsw}. Exactly one bit set -> candidate code; zero bits or more than one bit -> "none".
  - The candidate must be seen identically for DEBOUNCE_TICKS ticks before it is accepted.
  - Acceptance raises key_evt in the clk cycle after that tick and updates key_code.
  - No further event is issued until "none" has been seen for DEBOUNCE_TICKS ticks (release lockout).
  - Changing code without an intervening release restarts the count and produces no event.
- Entry FSM (acts only on key_evt):
  - S_A:
    - Digit: appended if len_a < MAX_DIGITS (operand shifts left 4, new digit in LSB); otherwise ignored.
    - Binary operator (+ - x / % ^) with len_a > 0: latch op_code and led, go to S_B.
    - '!' with len_a > 0: latch it, pulse calc_go, go to S_DONE.
    - '=', or any operator with len_a = 0: ignored.
  - S_B:
    - Digit: appended to B under the same MAX_DIGITS limit.
    - Binary operator with len_b = 0: replaces the latched operator.
    - '=' with len_b > 0: pulse calc_go, go to S_DONE.
    - Other operator keys: ignored.
  - S_DONE:
    - Digit: clears A, B, op and led, then starts a new A with that digit (state S_A).
    - Operator keys: ignored.
  - CE:
    - In S_A: drops the last A digit (operand shifts right 4).
    - In S_B with len_b > 0: drops the last B digit.
    - In S_B with len_b = 0: removes the operator and returns to S_A.
    - In S_DONE: no effect.
  - CLR in any state: same as reset except the divider and debounce counters keep running.
- calc_go rises in the same cycle the state register moves to S_DONE; operand_a, operand_b and op_code are already final in that cycle.
- Line buffer:
  - Layout: A digits from address 0, then the operator char, then B digits, then '=' (written at the calc_go event for binary operators and for '!'); all remaining bytes 0x20.
  - Worst case with MAX_DIGITS = 6 is 14 bytes; nothing is ever written beyond address 15.
  - ASCII: digits 0x30-0x39; + 0x2B, - 0x2D, x 0xD7, / 0x2F, % 0xF7, ^ 0x5E, ! 0x21, = 0x3D.
  - Every CE or CLR rewrites the affected bytes back to 0x20.
  - Read-before-write: if a read and a buffer update land in the same cycle, rd_data returns the pre-update byte.

Optional Feature:
KEY_REPEAT_EN:
- Defined: a digit key held past acceptance re-issues key_evt every 50 ticks (auto-repeat) until released.
- Operator, CLR and CE keys never repeat.
- Undefined: exactly one event per press, as described in Behaviour.

Test Plan:
- Hold sw[9] (digit 2) for 3 ticks, then release -> no key_evt. Hold it for 4 ticks -> exactly one key_evt, key_code = 2, operand_a = 0x002, buffer[0] = 0x32.
- Press 1, 2, dipsw[7], 3, dipsw[0] -> single calc_go; operand_a = 0x012, operand_b = 0x003, op_code = 0, led = 0x80; buffer = "12+3=" then 0x20 fill; entry_state = 2.
- Press 4, 5, 6, 7 with MAX_DIGITS = 3 -> operand_a = 0x456; the fourth press is ignored and buffer[3] stays 0x20.
- Press 5, dipsw[6], CE, CE -> state back to S_A, op/led cleared, operand_a = 0; buffer all 0x20.
- Assert sw = 12'h900 (two bits set) for 10 ticks -> no key_evt. Press 7, then assert rst for one cycle mid-debounce of the next key -> all outputs 0 and buffer all 0x20 on the following cycle.
- Press 3, dipsw[1] -> calc_go with op_code = 6 and buffer "3!=". Then press 8 -> operand_a = 0x008, state S_A, led = 0.
